// File: rtl/axis_if.sv
// AXI4-Stream bundle shared by frame sources and sinks.
// source/sink modports are the canonical names; master/slave are aliases for older blocks.
`timescale 1ns / 1ps

interface axis_if #(
  parameter int unsigned DWIDTH     = 256,
  parameter int unsigned KEEP_WIDTH = DWIDTH / 8
);
  logic [DWIDTH-1:0]     tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tvalid;
  logic                  tlast;
  logic                  tready;

  modport source (output tdata, output tkeep, output tvalid, output tlast, input tready);
  modport sink   (input tdata, input tkeep, input tvalid, input tlast, output tready);
  modport master (output tdata, output tkeep, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tkeep, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_frame_tx.sv
// AXIS frame transmitter: turns a byte-length command plus a word stream into AXIS beats.
// Define AXIS_FRAME_TX_ZERO_PAD_EN to zero the unkept bytes of the final beat.
`timescale 1ns / 1ps

module axis_frame_tx #(
  parameter int unsigned DWIDTH     = 256,
  parameter int unsigned KEEP_WIDTH = DWIDTH / 8,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [LEN_WIDTH-1:0] cmd_len,
  input  logic                 data_valid,
  output logic                 data_ready,
  input  logic [DWIDTH-1:0]    data,
  axis_if.source               m_axis,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 zero_len_err
);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  localparam logic [LEN_WIDTH:0] KeepW  = (LEN_WIDTH + 1)'(KEEP_WIDTH);
  localparam logic [LEN_WIDTH:0] KeepM1 = (LEN_WIDTH + 1)'(KEEP_WIDTH - 1);

  state_e                state_q;
  logic [LEN_WIDTH-1:0]  beats_left_q;
  logic [KEEP_WIDTH-1:0] last_keep_q;
  logic [DWIDTH-1:0]     tdata_q;
  logic [KEEP_WIDTH-1:0] tkeep_q;
  logic                  tvalid_q;
  logic                  tlast_q;
  logic                  frame_done_q;
  logic                  zero_len_err_q;

  logic                  data_hs;
  logic                  is_last;
  logic [LEN_WIDTH:0]    len_ext;
  logic [LEN_WIDTH:0]    rem_full;
  logic [LEN_WIDTH-1:0]  cmd_beats;
  logic [KEEP_WIDTH-1:0] cmd_keep;
  logic [KEEP_WIDTH-1:0] load_keep;
  logic [DWIDTH-1:0]     load_data;

  assign cmd_ready  = (state_q == StIdle);
  assign data_ready = (state_q == StSend) & (~tvalid_q | m_axis.tready);
  assign data_hs    = data_valid & data_ready;
  assign is_last    = (beats_left_q == LEN_WIDTH'(1));
  assign busy       = (state_q != StIdle) | tvalid_q;

  // Extra MSB keeps the round-up from overflowing near the top of the length range.
  always_comb begin
    len_ext   = {1'b0, cmd_len};
    cmd_beats = LEN_WIDTH'((len_ext + KeepM1) / KeepW);
    rem_full  = len_ext % KeepW;
    cmd_keep  = '0;
    for (int unsigned i = 0; i < KEEP_WIDTH; i++) begin
      cmd_keep[i] = (rem_full == '0) || (rem_full > (LEN_WIDTH + 1)'(i));
    end
  end

  always_comb begin
    load_keep = is_last ? last_keep_q : '1;
    load_data = data;
`ifdef AXIS_FRAME_TX_ZERO_PAD_EN
    if (is_last) begin
      for (int unsigned b = 0; b < KEEP_WIDTH; b++) begin
        if (!last_keep_q[b]) begin
          load_data[8*b +: 8] = 8'h00;
        end
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      beats_left_q   <= '0;
      last_keep_q    <= '0;
      tdata_q        <= '0;
      tkeep_q        <= '0;
      tvalid_q       <= 1'b0;
      tlast_q        <= 1'b0;
      frame_done_q   <= 1'b0;
      zero_len_err_q <= 1'b0;
    end else begin
      frame_done_q   <= tvalid_q & m_axis.tready & tlast_q;
      zero_len_err_q <= 1'b0;

      // A load in the same cycle as a drain replaces the beat with no bubble.
      if (data_hs) begin
        tdata_q  <= load_data;
        tkeep_q  <= load_keep;
        tlast_q  <= is_last;
        tvalid_q <= 1'b1;
      end else if (m_axis.tready) begin
        tvalid_q <= 1'b0;
      end

      unique case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            if (cmd_len == '0) begin
              zero_len_err_q <= 1'b1;
            end else begin
              beats_left_q <= cmd_beats;
              last_keep_q  <= cmd_keep;
              state_q      <= StSend;
            end
          end
        end
        StSend: begin
          if (data_hs) begin
            beats_left_q <= beats_left_q - LEN_WIDTH'(1);
            if (is_last) begin
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign m_axis.tdata  = tdata_q;
  assign m_axis.tkeep  = tkeep_q;
  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tlast  = tlast_q;
  assign frame_done    = frame_done_q;
  assign zero_len_err  = zero_len_err_q;

endmodule

// File: tb/tb_axis_frame_tx.sv
// Directed bench for axis_frame_tx with a beat scoreboard and a frame_done model.
`timescale 1ns / 1ps

module tb_axis_frame_tx;

  localparam int unsigned DW = 256;
  localparam int unsigned KW = 32;
  localparam int unsigned LW = 16;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [LW-1:0] cmd_len;
  logic          data_valid;
  logic          data_ready;
  logic [DW-1:0] data;
  logic          busy;
  logic          frame_done;
  logic          zero_len_err;

  axis_if #(.DWIDTH(DW), .KEEP_WIDTH(KW)) m_axis ();

  axis_frame_tx #(.DWIDTH(DW), .KEEP_WIDTH(KW), .LEN_WIDTH(LW)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_len      (cmd_len),
    .data_valid   (data_valid),
    .data_ready   (data_ready),
    .data         (data),
    .m_axis       (m_axis),
    .busy         (busy),
    .frame_done   (frame_done),
    .zero_len_err (zero_len_err)
  );

  always #5 clk = ~clk;

  beat_t         sb[$];
  beat_t         exp_beat;
  int            checks     = 0;
  int            errors     = 0;
  int            done_count = 0;
  int            beats_seen = 0;
  logic          done_exp   = 1'b0;
  int            done_base;
  logic [DW-1:0] w1, w2, w3, w4, w5;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_word();
    logic [DW-1:0] w;
    for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom();
    return w;
  endfunction

  function automatic logic [DW-1:0] pad(input logic [DW-1:0] d, input logic [KW-1:0] k,
                                        input logic last);
    logic [DW-1:0] r;
    r = d;
`ifdef AXIS_FRAME_TX_ZERO_PAD_EN
    if (last) for (int i = 0; i < KW; i++) if (!k[i]) r[i*8 +: 8] = 8'h00;
`endif
    return r;
  endfunction

  task automatic send_cmd(input logic [LW-1:0] len);
    int n;
    n = 0;
    cmd_valid = 1'b1;
    cmd_len   = len;
    @(negedge clk);
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_accept", cmd_ready, 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic send_word(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic last);
    int n;
    n = 0;
    data_valid = 1'b1;
    data       = d;
    @(negedge clk);
    while (!data_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("data_accept", data_ready, 1);
    sb.push_back(beat_t'{data: pad(d, k, last), keep: k, last: last});
    @(posedge clk);
    #1;
    data_valid = 1'b0;
  endtask

  // Output monitor: every handshaken beat is popped and compared; frame_done follows tlast.
  always @(negedge clk) begin
    if (rst) begin
      done_exp = 1'b0;
    end else begin
      chk("frame_done", frame_done, done_exp);
      if (frame_done) done_count++;
      done_exp = m_axis.tvalid & m_axis.tready & m_axis.tlast;
      if (m_axis.tvalid && m_axis.tready) begin
        checks++;
        assert (sb.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_beat observed=%0h expected=none", m_axis.tdata);
        end
        if (sb.size() != 0) begin
          exp_beat = sb.pop_front();
          chk("beat_tdata", m_axis.tdata, exp_beat.data);
          chk("beat_tkeep", m_axis.tkeep, exp_beat.keep);
          chk("beat_tlast", m_axis.tlast, exp_beat.last);
          beats_seen++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_len = '0; data_valid = 1'b0; data = '0;
    m_axis.tready = 1'b0;
    w1 = rnd_word(); w2 = rnd_word(); w3 = rnd_word(); w4 = rnd_word(); w5 = rnd_word();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_tvalid", m_axis.tvalid, 0);
    chk("rst_tdata", m_axis.tdata, 0);
    chk("rst_tkeep", m_axis.tkeep, 0);
    chk("rst_tlast", m_axis.tlast, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_zero_len_err", zero_len_err, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_data_ready", data_ready, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    m_axis.tready = 1'b1;

    // 64 bytes: two full beats back to back
    send_cmd(16'd64);
    chk("t1_busy", busy, 1);
    send_word(w1, '1, 1'b0);
    chk("t1_latency_tvalid", m_axis.tvalid, 1);
    chk("t1_latency_tdata", m_axis.tdata, w1);
    send_word(w2, '1, 1'b1);
    repeat (3) @(posedge clk);
    #1;

    // 33 bytes: final beat keeps a single byte
    send_cmd(16'd33);
    send_word(w1, '1, 1'b0);
    send_word(w2, 32'h0000_0001, 1'b1);
    chk("t2_tkeep", m_axis.tkeep, 32'h0000_0001);
    chk("t2_tlast", m_axis.tlast, 1);
`ifdef AXIS_FRAME_TX_ZERO_PAD_EN
    chk("t2_pad_upper", m_axis.tdata[255:8], 0);
`else
    chk("t2_passthru", m_axis.tdata, w2);
`endif
    repeat (3) @(posedge clk);
    #1;

    // 96 bytes with a 3-cycle stall after beat 1
    send_cmd(16'd96);
    send_word(w1, '1, 1'b0);
    m_axis.tready = 1'b0;
    data_valid = 1'b1;
    data = w2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t3_stall_data_ready", data_ready, 0);
      chk("t3_stall_tvalid", m_axis.tvalid, 1);
      chk("t3_stall_tdata", m_axis.tdata, w1);
      chk("t3_stall_tkeep", m_axis.tkeep, {KW{1'b1}});
      chk("t3_stall_tlast", m_axis.tlast, 0);
    end
    @(posedge clk); #1;
    m_axis.tready = 1'b1;
    send_word(w2, '1, 1'b0);
    send_word(w3, '1, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("t3_sb_drained", sb.size(), 0);

    // zero-length command
    send_cmd(16'd0);
    chk("t4_zero_len_err", zero_len_err, 1);
    chk("t4_tvalid", m_axis.tvalid, 0);
    chk("t4_cmd_ready", cmd_ready, 1);
    @(posedge clk); #1;
    chk("t4_zero_len_err_clr", zero_len_err, 0);
    chk("t4_tvalid_idle", m_axis.tvalid, 0);
    chk("t4_busy", busy, 0);

    // 32 then 5 bytes back to back
    done_base = done_count;
    send_cmd(16'd32);
    send_word(w1, '1, 1'b1);
    send_cmd(16'd5);
    chk("t5_bubble", m_axis.tvalid, 0);
    send_word(w2, 32'h0000_001F, 1'b1);
    chk("t5_tkeep", m_axis.tkeep, 32'h0000_001F);
    repeat (3) @(posedge clk);
    #1;
    chk("t5_done_pulses", done_count - done_base, 2);

    // reset while beat 2 of a 4-beat frame is stalled
    send_cmd(16'd128);
    send_word(w1, '1, 1'b0);
    send_word(w2, '1, 1'b0);
    m_axis.tready = 1'b0;
    data_valid = 1'b1;
    data = w3;
    @(negedge clk);
    chk("t6_stalled", m_axis.tvalid, 1);
    #1;
    rst = 1'b1;
    #1;
    chk("t6_rst_tvalid", m_axis.tvalid, 0);
    chk("t6_rst_data_ready", data_ready, 0);
    chk("t6_rst_busy", busy, 0);
    data_valid = 1'b0;
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    m_axis.tready = 1'b1;
    chk("t6_cmd_ready", cmd_ready, 1);
    send_cmd(16'd40);
    send_word(w4, '1, 1'b0);
    send_word(w5, 32'h0000_00FF, 1'b1);
    repeat (4) @(posedge clk);
    #1;

    chk("end_sb_empty", sb.size(), 0);
    chk("end_beats_seen", beats_seen, 12);
    chk("end_done_count", done_count, 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
